// File: rtl/placement_cost_eval.sv
// Wirelength evaluator: walks the edge list, reads both endpoint positions and accumulates
// Manhattan cost, k-hop cost, longest edge and unplaced/overlap counts. Five cycles per edge.
module placement_cost_eval #(
    parameter int unsigned NODE_W  = 7,
    parameter int unsigned COORD_W = 8,
    parameter int unsigned EDGE_AW = 8,
    parameter int unsigned SUM_W   = 32,
    parameter int unsigned HOP     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [EDGE_AW:0]          n_edge,
    output logic                      busy,
    output logic                      done,
    output logic                      edge_re,
    output logic [EDGE_AW-1:0]        edge_addr,
    input  logic [NODE_W-1:0]         edge_a,
    input  logic [NODE_W-1:0]         edge_b,
    output logic                      pos_re,
    output logic [NODE_W-1:0]         pos_addr,
    input  logic signed [COORD_W-1:0] pos_x,
    input  logic signed [COORD_W-1:0] pos_y,
    output logic [SUM_W-1:0]          sum_wl,
    output logic [SUM_W-1:0]          sum_hop,
    output logic [COORD_W:0]          max_len,
    output logic [EDGE_AW:0]          unplaced_edges,
    output logic [EDGE_AW:0]          overlap_edges
);

    localparam int unsigned DW = COORD_W + 1;
    localparam logic [COORD_W-1:0] Unplaced = '1;

    typedef enum logic [2:0] {
        StIdle, StEdge, StPosA, StPosB, StDiff, StAcc, StDone
    } state_e;

    state_e             state_q;
    logic [EDGE_AW:0]   n_edge_q;
    logic [EDGE_AW:0]   idx_q;
    logic [NODE_W-1:0]  pos_addr_q;
    logic [COORD_W-1:0] ax_q, ay_q;
    logic [DW-1:0]      dx_q, dy_q;
    logic               unplaced_q, overlap_q;

    // Endpoint A address comes straight from the edge ROM; afterwards the latched B id is held.
    assign pos_addr = (state_q == StPosA) ? edge_a : pos_addr_q;

    logic signed [DW-1:0] ax_ext, ay_ext, bx_ext, by_ext, diff_x, diff_y;
    logic [DW-1:0]        abs_x, abs_y;
    logic                 unplaced_now;
    logic [DW:0]          len;
    logic [31:0]          hop_x, hop_y, hop_inc;
    logic [EDGE_AW:0]     idx_inc;

    always_comb begin
        ax_ext = {ax_q[COORD_W-1], ax_q};
        ay_ext = {ay_q[COORD_W-1], ay_q};
        bx_ext = {pos_x[COORD_W-1], pos_x};
        by_ext = {pos_y[COORD_W-1], pos_y};
        diff_x = ax_ext - bx_ext;
        diff_y = ay_ext - by_ext;
        abs_x  = diff_x[DW-1] ? -diff_x : diff_x;
        abs_y  = diff_y[DW-1] ? -diff_y : diff_y;
        unplaced_now = (ax_q == Unplaced) || (ay_q == Unplaced) ||
                       (pos_x == Unplaced) || (pos_y == Unplaced);
        len     = {1'b0, dx_q} + {1'b0, dy_q};
        hop_x   = (32'(dx_q) + HOP - 1) / HOP;
        hop_y   = (32'(dy_q) + HOP - 1) / HOP;
        hop_inc = hop_x + hop_y - 32'd1;
        idx_inc = idx_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            n_edge_q       <= '0;
            idx_q          <= '0;
            pos_addr_q     <= '0;
            ax_q           <= '0;
            ay_q           <= '0;
            dx_q           <= '0;
            dy_q           <= '0;
            unplaced_q     <= 1'b0;
            overlap_q      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            edge_re        <= 1'b0;
            edge_addr      <= '0;
            pos_re         <= 1'b0;
            sum_wl         <= '0;
            sum_hop        <= '0;
            max_len        <= '0;
            unplaced_edges <= '0;
            overlap_edges  <= '0;
        end else begin
            done    <= 1'b0;
            edge_re <= 1'b0;
            pos_re  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        n_edge_q       <= n_edge;
                        idx_q          <= '0;
                        busy           <= 1'b1;
                        sum_wl         <= '0;
                        sum_hop        <= '0;
                        max_len        <= '0;
                        unplaced_edges <= '0;
                        overlap_edges  <= '0;
                        if (n_edge == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            state_q   <= StEdge;
                            edge_re   <= 1'b1;
                            edge_addr <= '0;
                        end
                    end
                end
                StEdge: begin
                    state_q <= StPosA;
                    pos_re  <= 1'b1;
                end
                StPosA: begin
                    pos_addr_q <= edge_b;
                    pos_re     <= 1'b1;
                    state_q    <= StPosB;
                end
                StPosB: begin
                    ax_q    <= pos_x;
                    ay_q    <= pos_y;
                    state_q <= StDiff;
                end
                StDiff: begin
                    dx_q       <= abs_x;
                    dy_q       <= abs_y;
                    unplaced_q <= unplaced_now;
                    overlap_q  <= !unplaced_now && (abs_x == '0) && (abs_y == '0);
                    state_q    <= StAcc;
                end
                StAcc: begin
                    if (unplaced_q) begin
                        unplaced_edges <= unplaced_edges + 1'b1;
                    end else if (overlap_q) begin
                        overlap_edges <= overlap_edges + 1'b1;
                    end else begin
                        sum_wl  <= sum_wl + SUM_W'(len) - SUM_W'(1);
                        sum_hop <= sum_hop + SUM_W'(hop_inc);
                        if (len > {1'b0, max_len}) begin
                            max_len <= len[DW-1:0];
                        end
                    end
                    idx_q <= idx_inc;
                    if (idx_inc == n_edge_q) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                    end else begin
                        state_q   <= StEdge;
                        edge_re   <= 1'b1;
                        edge_addr <= idx_inc[EDGE_AW-1:0];
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_placement_cost_eval.sv
// Directed bench for placement_cost_eval with behavioural edge ROM and position RAMs.
module tb_placement_cost_eval;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [8:0]        n_edge = '0;
    logic              busy, done, edge_re, pos_re;
    logic [7:0]        edge_addr;
    logic [6:0]        edge_a = '0, edge_b = '0, pos_addr;
    logic signed [7:0] pos_x = '0, pos_y = '0;
    logic [31:0]       sum_wl, sum_hop;
    logic [8:0]        max_len, unplaced_edges, overlap_edges;

    logic [6:0] ea [256];
    logic [6:0] eb [256];
    logic [7:0] px [128];
    logic [7:0] py [128];

    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int re_cnt = 0;

    placement_cost_eval #(
        .NODE_W (7), .COORD_W(8), .EDGE_AW(8), .SUM_W(32), .HOP(2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .n_edge         (n_edge),
        .busy           (busy),
        .done           (done),
        .edge_re        (edge_re),
        .edge_addr      (edge_addr),
        .edge_a         (edge_a),
        .edge_b         (edge_b),
        .pos_re         (pos_re),
        .pos_addr       (pos_addr),
        .pos_x          (pos_x),
        .pos_y          (pos_y),
        .sum_wl         (sum_wl),
        .sum_hop        (sum_hop),
        .max_len        (max_len),
        .unplaced_edges (unplaced_edges),
        .overlap_edges  (overlap_edges)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (edge_re) begin
            edge_a <= ea[edge_addr];
            edge_b <= eb[edge_addr];
        end
        if (pos_re) begin
            pos_x <= px[pos_addr];
            pos_y <= py[pos_addr];
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (edge_re === 1'b1) re_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_node(input int id, input int x, input int y);
        px[id] = 8'(x);
        py[id] = 8'(y);
    endtask

    task automatic set_edge(input int k, input int a, input int b);
        ea[k] = 7'(a);
        eb[k] = 7'(b);
    endtask

    task automatic check_res(input string tag, input int wl, input int hop, input int mx,
                             input int un, input int ov);
        check({tag, ".sum_wl"}, sum_wl, wl);
        check({tag, ".sum_hop"}, sum_hop, hop);
        check({tag, ".max_len"}, 32'(max_len), mx);
        check({tag, ".unplaced"}, 32'(unplaced_edges), un);
        check({tag, ".overlap"}, 32'(overlap_edges), ov);
    endtask

    // Pulses start, counts cycles to done; optionally fires a second start at cycle extra_at.
    task automatic run_job(input string tag, input int n, input int extra_at, input int exp_lat,
                           input int exp_re);
        int lat, d0, r0;
        d0 = done_cnt;
        r0 = re_cnt;
        @(negedge clk);
        n_edge = 9'(n);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            if (lat == extra_at) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".busy_in_done"}, 32'(busy), 1);
        @(negedge clk);
        @(negedge clk);
        check({tag, ".done_pulses"}, done_cnt - d0, 1);
        check({tag, ".edge_re_cycles"}, re_cnt - r0, exp_re);
        check({tag, ".busy_after"}, 32'(busy), 0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) set_node(i, 0, 0);
        for (int i = 0; i < 256; i++) set_edge(i, 0, 0);
        // Test 2 nodes
        set_node(0, 0, 0);   set_node(1, 3, 5);
        // Test 3 nodes
        set_node(2, 10, 10); set_node(3, 11, 10); set_node(4, 11, 11);
        set_node(5, -5, -3); set_node(6, -5, -4);
        // Test 4 nodes
        set_node(7, -1, 0);  set_node(8, 1, 1);   set_node(9, 1, 4);
        // Test 5 nodes
        set_node(10, 2, 2);  set_node(11, 2, 2);
        // Test 6: edge i from node 12 (0,0) to node 13+i at (i, i+1)
        set_node(12, 0, 0);
        for (int i = 0; i < 10; i++) set_node(13 + i, i, i + 1);

        #1;
        check("reset.busy", 32'(busy), 0);
        check("reset.done", 32'(done), 0);
        check_res("reset", 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        run_job("t1_empty", 0, 0, 1, 0);
        check_res("t1", 0, 0, 0, 0, 0);

        set_edge(0, 0, 1);
        run_job("t2_single", 1, 0, 6, 1);
        check_res("t2", 7, 4, 8, 0, 0);

        set_edge(0, 2, 3); set_edge(1, 3, 4); set_edge(2, 5, 6);
        run_job("t3_adjacent", 3, 0, 16, 3);
        check_res("t3", 0, 0, 1, 0, 0);

        set_edge(0, 8, 7); set_edge(1, 8, 9);
        run_job("t4_unplaced", 2, 0, 11, 2);
        check_res("t4", 2, 1, 3, 1, 0);

        set_edge(0, 10, 11);
        run_job("t5_overlap", 1, 3, 6, 1);
        check_res("t5", 0, 0, 0, 0, 1);

        // Test 6: abort with reset after three edges, then rerun cleanly.
        for (int i = 0; i < 10; i++) set_edge(i, 12, 13 + i);
        begin
            int d0;
            d0 = done_cnt;
            @(negedge clk);
            n_edge = 9'd10;
            start  = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (16) @(negedge clk);
            check("t6.partial_wl", sum_wl, 6);
            check("t6.busy_before", 32'(busy), 1);
            #2 reset = 1'b0;
            #1;
            check("t6.busy_reset", 32'(busy), 0);
            check_res("t6_reset", 0, 0, 0, 0, 0);
            repeat (3) @(negedge clk);
            reset = 1'b1;
            repeat (2) @(negedge clk);
            check("t6.no_done", done_cnt - d0, 0);
        end
        run_job("t6_rerun", 10, 0, 51, 10);
        check_res("t6", 90, 45, 19, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
